// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the requesters, the arbiter and the FIFO producer side.
// The master modport is the arbiter's view; slave is the requester/FIFO view.
interface fifo_wr_arbiter_if #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned ID_WIDTH = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]            req;
  logic [N_REQ*DATA_WIDTH-1:0] wdata;
  logic                        full;
  logic [N_REQ-1:0]            grant;
  logic [ID_WIDTH-1:0]         owner;
  logic                        busy;
  logic                        w_en;
  logic [DATA_WIDTH-1:0]       w_data;

  modport master (
    input  req, wdata, full,
    output grant, owner, busy, w_en, w_data
  );

  modport slave (
    output req, wdata, full,
    input  grant, owner, busy, w_en, w_data
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter with burst locking for the async-FIFO write port.
// The owner keeps the port for up to MAX_BURST beats; one idle cycle separates bursts.
module fifo_wr_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic               clk,
  input  logic               w_rst,
  fifo_wr_arbiter_if.master  bus
);
  localparam int unsigned ID_WIDTH  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_WIDTH = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state_q, state_d;
  logic [N_REQ-1:0]      grant_q, grant_d;
  logic [ID_WIDTH-1:0]   owner_q, owner_d;
  logic [ID_WIDTH-1:0]   last_q, last_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  found_c;
  logic [ID_WIDTH-1:0]   pick_c;
  logic                  xfer_c;
  logic [DATA_WIDTH-1:0] slice [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign slice[i] = bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Rotating priority search starting just after the last owner.
  always_comb begin
    int unsigned idx;
    found_c = 1'b0;
    pick_c  = '0;
    idx     = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(last_q) + k) % N_REQ;
      if (!found_c && bus.req[ID_WIDTH'(idx)]) begin
        found_c = 1'b1;
        pick_c  = ID_WIDTH'(idx);
      end
    end
  end

  // A beat moves only while the owner still requests and the FIFO has room.
  assign xfer_c     = (state_q == BURST) & bus.req[owner_q] & ~bus.full;
  assign bus.w_en   = xfer_c;
  assign bus.w_data = (|grant_q) ? slice[owner_q] : '0;
  assign bus.grant  = grant_q;
  assign bus.owner  = owner_q;
  assign bus.busy   = (state_q == BURST);

  always_ff @(posedge clk or negedge w_rst) begin
    if (!w_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= ID_WIDTH'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found_c) begin
          state_d = BURST;
          grant_d = N_REQ'(1) << pick_c;
          owner_d = pick_c;
          cnt_d   = '0;
        end
      end
      BURST: begin
        // Release on the final beat or when the owner withdraws its request.
        if ((xfer_c && (cnt_q == CNT_WIDTH'(MAX_BURST - 1))) || !bus.req[owner_q]) begin
          state_d = IDLE;
          grant_d = '0;
          owner_d = '0;
          last_d  = owner_q;
          cnt_d   = '0;
        end else if (xfer_c) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: burst length, rotation, full stall, early release,
// mid-burst reset and single-beat mode.
module tb_fifo_wr_arbiter;
  logic clk = 1'b0;
  logic w_rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  fifo_wr_arbiter_if #(.N_REQ(4), .DATA_WIDTH(8)) bus ();
  fifo_wr_arbiter_if #(.N_REQ(4), .DATA_WIDTH(8)) bus1 ();

  fifo_wr_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) u_dut (
    .clk(clk), .w_rst(w_rst), .bus(bus)
  );
  fifo_wr_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .w_rst(w_rst), .bus(bus1)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    w_rst       = 1'b0;
    bus.req     = '0;
    bus.full    = 1'b0;
    bus.wdata   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    bus1.req    = '0;
    bus1.full   = 1'b0;
    bus1.wdata  = {8'h77, 8'h66, 8'h55, 8'h44};
    @(posedge clk);
    @(posedge clk);
    #1 w_rst = 1'b1;
  endtask

  task automatic test_reset();
    w_rst   = 1'b0;
    bus.req = 4'b1111;
    bus.full = 1'b0;
    bus.wdata = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    @(posedge clk);
    @(negedge clk);
    total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL rst_grant got=%b want=0000", bus.grant); end
    total++; if (bus.owner !== 2'd0) begin bad++; $display("FAIL rst_owner got=%0d want=0", bus.owner); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
    total++; if (bus.w_en !== 1'b0) begin bad++; $display("FAIL rst_w_en got=%b want=0", bus.w_en); end
    total++; if (bus.w_data !== 8'h00) begin bad++; $display("FAIL rst_w_data got=%h want=00", bus.w_data); end
    @(posedge clk);
    #1 w_rst = 1'b1;
    @(negedge clk);
    total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL rst_cycle0_grant got=%b want=0000", bus.grant); end
    @(posedge clk); #1;
    bus.req = 4'b0000;
  endtask

  task automatic test_single_burst();
    logic [3:0] eg [10];
    logic       ee [10];
    int n;
    eg = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0};
    ee = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    apply_reset();
    n = 0;
    for (int c = 0; c < 10; c++) begin
      bus.req = (n < 6) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      total++; if (bus.grant !== eg[c]) begin bad++; $display("FAIL burst_grant c=%0d got=%b want=%b", c, bus.grant, eg[c]); end
      total++; if (bus.w_en !== ee[c]) begin bad++; $display("FAIL burst_w_en c=%0d got=%b want=%b", c, bus.w_en, ee[c]); end
      if (ee[c]) begin
        total++; if (bus.w_data !== 8'hC2) begin bad++; $display("FAIL burst_w_data c=%0d got=%h want=c2", c, bus.w_data); end
      end
      if (bus.w_en === 1'b1) n++;
      @(posedge clk); #1;
    end
    total++; if (n !== 6) begin bad++; $display("FAIL burst_beats got=%0d want=6", n); end
  endtask

  task automatic test_round_robin();
    logic [7:0] vals [4];
    logic [3:0] eg;
    logic       ee;
    int k, pos, o;
    vals = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    apply_reset();
    bus.req = 4'b1111;
    for (int c = 0; c < 25; c++) begin
      ee = 1'b0; eg = 4'b0000; o = 0;
      if (c >= 1) begin
        k = (c - 1) / 5; pos = (c - 1) % 5; o = k % 4;
        if (pos < 4) begin ee = 1'b1; eg = 4'b0001 << o; end
      end
      @(negedge clk);
      total++; if (bus.grant !== eg) begin bad++; $display("FAIL rr_grant c=%0d got=%b want=%b", c, bus.grant, eg); end
      total++; if (bus.w_en !== ee) begin bad++; $display("FAIL rr_w_en c=%0d got=%b want=%b", c, bus.w_en, ee); end
      if (ee) begin
        total++; if (bus.w_data !== vals[o]) begin bad++; $display("FAIL rr_w_data c=%0d got=%h want=%h", c, bus.w_data, vals[o]); end
        total++; if (bus.owner !== 2'(o)) begin bad++; $display("FAIL rr_owner c=%0d got=%0d want=%0d", c, bus.owner, o); end
      end
      @(posedge clk); #1;
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_full_stall();
    logic [7:0] vals [4];
    logic [3:0] eg [9];
    logic       ef [9];
    logic       ee [9];
    int n;
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    eg = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0};
    ef = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ee = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    apply_reset();
    n = 0;
    for (int c = 0; c < 9; c++) begin
      bus.req   = (n < 4) ? 4'b0010 : 4'b0000;
      bus.full  = ef[c];
      bus.wdata = {8'hD3, 8'hC2, vals[n % 4], 8'hA0};
      @(negedge clk);
      total++; if (bus.grant !== eg[c]) begin bad++; $display("FAIL full_grant c=%0d got=%b want=%b", c, bus.grant, eg[c]); end
      total++; if (bus.w_en !== ee[c]) begin bad++; $display("FAIL full_w_en c=%0d got=%b want=%b", c, bus.w_en, ee[c]); end
      if (ee[c]) begin
        total++; if (bus.w_data !== vals[n % 4]) begin bad++; $display("FAIL full_w_data c=%0d got=%h want=%h", c, bus.w_data, vals[n % 4]); end
      end
      if (bus.w_en === 1'b1) n++;
      @(posedge clk); #1;
    end
    bus.full = 1'b0;
    total++; if (n !== 4) begin bad++; $display("FAIL full_writes got=%0d want=4", n); end
  endtask

  task automatic test_early_release();
    logic [3:0] eg [6];
    logic       ee [6];
    eg = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h4};
    ee = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      bus.req = (c < 3) ? 4'b0101 : 4'b0100;
      @(negedge clk);
      total++; if (bus.grant !== eg[c]) begin bad++; $display("FAIL early_grant c=%0d got=%b want=%b", c, bus.grant, eg[c]); end
      total++; if (bus.w_en !== ee[c]) begin bad++; $display("FAIL early_w_en c=%0d got=%b want=%b", c, bus.w_en, ee[c]); end
      if (c == 1) begin
        total++; if (bus.w_data !== 8'hA0) begin bad++; $display("FAIL early_w_data got=%h want=a0", bus.w_data); end
      end
      @(posedge clk); #1;
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    bus.req = 4'b0100;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (bus.grant !== 4'b0100) begin bad++; $display("FAIL midrst_pre_grant got=%b want=0100", bus.grant); end
    @(posedge clk); #1;
    #1 w_rst = 1'b0;
    #1;
    total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL midrst_grant got=%b want=0000", bus.grant); end
    total++; if (bus.w_en !== 1'b0) begin bad++; $display("FAIL midrst_w_en got=%b want=0", bus.w_en); end
    total++; if (bus.w_data !== 8'h00) begin bad++; $display("FAIL midrst_w_data got=%h want=00", bus.w_data); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
    bus.req = 4'b1010;
    @(posedge clk);
    @(posedge clk);
    #1 w_rst = 1'b1;
    @(negedge clk);
    total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL midrst_idle_grant got=%b want=0000", bus.grant); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (bus.grant !== 4'b0010) begin bad++; $display("FAIL midrst_first_grant got=%b want=0010", bus.grant); end
    total++; if (bus.owner !== 2'd1) begin bad++; $display("FAIL midrst_owner got=%0d want=1", bus.owner); end
    total++; if (bus.w_data !== 8'hB1) begin bad++; $display("FAIL midrst_w_data_post got=%h want=b1", bus.w_data); end
    @(posedge clk); #1;
    bus.req = 4'b0000;
  endtask

  task automatic test_single_beat();
    logic [3:0] eg [8];
    logic [7:0] ed;
    eg = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h1, 4'h0, 4'h2};
    apply_reset();
    bus1.req = 4'b0011;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ed = (eg[c] == 4'h1) ? 8'h44 : 8'h55;
      total++; if (bus1.grant !== eg[c]) begin bad++; $display("FAIL sb_grant c=%0d got=%b want=%b", c, bus1.grant, eg[c]); end
      total++; if (bus1.w_en !== (eg[c] != 4'h0)) begin bad++; $display("FAIL sb_w_en c=%0d got=%b want=%b", c, bus1.w_en, (eg[c] != 4'h0)); end
      if (eg[c] != 4'h0) begin
        total++; if (bus1.w_data !== ed) begin bad++; $display("FAIL sb_w_data c=%0d got=%h want=%h", c, bus1.w_data, ed); end
      end
      @(posedge clk); #1;
    end
    bus1.req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_full_stall();
    test_early_release();
    test_reset_mid_burst();
    test_single_beat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
